// File: rtl/core_scheduler_if.sv
// Scheduler-to-core bundle: fetch port, LSU handshake, ALU controls, register selects.
// Pure wiring; no state or latency of its own.
// Flow control: the fetch request is held until a response; the LSU stalls via busy.
interface core_scheduler_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   io_start;
  logic                   io_done;
  logic                   io_instr_req_valid;
  logic [PC_WIDTH-1:0]    io_instr_req_addr;
  logic                   io_instr_resp_valid;
  logic [INSTR_WIDTH-1:0] io_instr_resp_data;
  logic                   io_lsu_req;
  logic                   io_lsu_busy;
  logic                   io_alu_execute;
  logic [3:0]             io_alu_operation;
  logic                   io_alu_compare;
  logic [7:0]             io_alu_result;
  logic [3:0]             io_rd_sel;
  logic [3:0]             io_rs_sel;
  logic [3:0]             io_rt_sel;
  logic [7:0]             io_imm;
  logic                   io_reg_write;
  logic [PC_WIDTH-1:0]    io_pc;

  // Scheduler side
  modport master (
    input  io_start, io_instr_resp_valid, io_instr_resp_data, io_lsu_busy, io_alu_result,
    output io_done, io_instr_req_valid, io_instr_req_addr, io_lsu_req, io_alu_execute,
    output io_alu_operation, io_alu_compare, io_rd_sel, io_rs_sel, io_rt_sel, io_imm,
    output io_reg_write, io_pc
  );

  // Core / memory side
  modport slave (
    output io_start, io_instr_resp_valid, io_instr_resp_data, io_lsu_busy, io_alu_result,
    input  io_done, io_instr_req_valid, io_instr_req_addr, io_lsu_req, io_alu_execute,
    input  io_alu_operation, io_alu_compare, io_rd_sel, io_rs_sel, io_rt_sel, io_imm,
    input  io_reg_write, io_pc
  );
endinterface

// File: rtl/core_scheduler.sv
// Per-core control FSM: fetch, decode, LSU wait, ALU execute, PC/NZP update, kernel done.
// Latency: 6 cycles per non-memory instruction with a same-cycle fetch response.
// Backpressure: fetch request held until a response; WAIT stalls while io_lsu_busy is high.
module core_scheduler #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  core_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REQUEST, S_WAIT, S_EXECUTE, S_UPDATE, S_DONE
  } state_t;

  localparam logic [3:0] OP_BR  = 4'h1;
  localparam logic [3:0] OP_CMP = 4'h2;
  localparam logic [3:0] OP_LDR = 4'h8;
  localparam logic [3:0] OP_STR = 4'h9;
  localparam logic [3:0] OP_CON = 4'hA;
  localparam logic [3:0] OP_RET = 4'hF;

  state_t                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [2:0]             nzp_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   req_vld_q;
  logic                   lsu_req_q;
  logic                   alu_exec_q;
  logic                   alu_cmp_q;
  logic                   reg_write_q;
  logic                   done_q;

  logic [3:0]          opcode;
  logic                is_mem, is_alu, is_cmp, is_writer, is_ret, is_br, br_taken;
  logic [PC_WIDTH-1:0] pc_d;
  logic                unused_result_hi;

  // Decode from the latched instruction; stable from DECODE through UPDATE
  assign opcode    = instr_q[15:12];
  assign is_mem    = (opcode == OP_LDR) || (opcode == OP_STR);
  assign is_cmp    = (opcode == OP_CMP);
  assign is_alu    = (opcode >= OP_CMP) && (opcode <= 4'h7);
  assign is_writer = ((opcode >= 4'h3) && (opcode <= 4'h7)) || (opcode == OP_LDR) || (opcode == OP_CON);
  assign is_ret    = (opcode == OP_RET);
  assign is_br     = (opcode == OP_BR);
  assign br_taken  = is_br && ((instr_q[11:9] & nzp_q) != 3'b000);

  // Only NZP bits of the ALU output matter here
  assign unused_result_hi = ^bus.io_alu_result[7:3];

  // PC value written in UPDATE: branch target (zero-extended) or wrapping increment
  always_comb begin
    pc_d = pc_q + PC_WIDTH'(1);
    if (br_taken) begin
      pc_d = PC_WIDTH'(instr_q[7:0]);
    end
  end

  // Main sequencer; every strobe is registered on entry to the state that owns it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      nzp_q       <= 3'b000;
      instr_q     <= '0;
      req_vld_q   <= 1'b0;
      lsu_req_q   <= 1'b0;
      alu_exec_q  <= 1'b0;
      alu_cmp_q   <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.io_start) begin
            state_q   <= S_FETCH;
            req_vld_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.io_instr_resp_valid) begin
            instr_q   <= bus.io_instr_resp_data;
            req_vld_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q   <= S_REQUEST;
          lsu_req_q <= is_mem;
        end
        S_REQUEST: begin
          state_q   <= S_WAIT;
          lsu_req_q <= 1'b0;
        end
        S_WAIT: begin
          if (!bus.io_lsu_busy) begin
            state_q    <= S_EXECUTE;
            alu_exec_q <= is_alu;
            alu_cmp_q  <= is_cmp;
          end
        end
        S_EXECUTE: begin
          state_q     <= S_UPDATE;
          alu_exec_q  <= 1'b0;
          alu_cmp_q   <= 1'b0;
          reg_write_q <= is_writer;
        end
        S_UPDATE: begin
          reg_write_q <= 1'b0;
          pc_q        <= pc_d;
          if (is_cmp) begin
            nzp_q <= bus.io_alu_result[2:0];
          end
          if (is_ret) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_FETCH;
            req_vld_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.io_start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            pc_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.io_done            = done_q;
  assign bus.io_instr_req_valid = req_vld_q;
  assign bus.io_instr_req_addr  = pc_q;
  assign bus.io_pc              = pc_q;
  assign bus.io_lsu_req         = lsu_req_q;
  assign bus.io_alu_execute     = alu_exec_q;
  assign bus.io_alu_compare     = alu_cmp_q;
  assign bus.io_reg_write       = reg_write_q;
  assign bus.io_alu_operation   = opcode;
  assign bus.io_rd_sel          = instr_q[11:8];
  assign bus.io_rs_sel          = instr_q[7:4];
  assign bus.io_rt_sel          = instr_q[3:0];
  assign bus.io_imm             = instr_q[7:0];

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: an ISA-level interpreter predicts each instruction's
// fetch address, strobes and cycle cost; a monitor compares what the DUT does.
// Fetch responses and LSU busy are driven by small behavioural memory/LSU models.
module tb_core_scheduler;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  core_scheduler_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus();

  core_scheduler #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] addr;
    logic [3:0] op;
    logic [3:0] rd, rs, rt;
    logic [7:0] imm;
    bit         alu, cmp, wr, mem;
    int         lat;
  } exp_t;

  int checks = 0;
  int failures = 0;

  logic [15:0] prog [256];
  logic [7:0]  res_arr [512];
  int          busy_arr [512];
  int          delay_arr [512];
  exp_t        exp_q [$];
  logic [2:0]  nzp_model;
  bit          resp_en = 0;
  bit          mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Instruction memory: random response delay, random noise while no fetch is pending
  int k_resp = 0;
  int dly = 0;
  int cur_b = 0;
  always @(posedge clock) begin
    #1;
    if (!resp_en) begin
      bus.io_instr_resp_valid = 1'b0;
      bus.io_instr_resp_data  = '0;
      bus.io_alu_result       = '0;
      dly = 0;
    end else if (bus.io_instr_req_valid) begin
      if (dly == 0) begin
        bus.io_instr_resp_valid = 1'b1;
        bus.io_instr_resp_data  = prog[bus.io_instr_req_addr];
        bus.io_alu_result       = res_arr[k_resp];
        cur_b = busy_arr[k_resp];
        k_resp++;
      end else begin
        bus.io_instr_resp_valid = 1'b0;
        dly--;
      end
    end else begin
      bus.io_instr_resp_valid = ($urandom_range(0, 3) == 0);
      bus.io_instr_resp_data  = 16'($urandom);
      dly = delay_arr[k_resp];
      if (bus.io_done) k_resp = 0;
    end
  end

  // LSU: busy for cur_b cycles after each request
  int busy_cnt = 0;
  always begin
    @(negedge clock);
    if (bus.io_lsu_req === 1'b1) busy_cnt = cur_b;
    @(posedge clock);
    #1;
    bus.io_lsu_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  // Monitor: one record per fetched instruction, closed at the next fetch or at DONE
  exp_t cur;
  bit   open = 0;
  bit   req_prev = 0, done_prev = 0;
  int   cyc = 0, hs_cyc = 0;
  int   n_exec = 0, n_cmp = 0, n_wr = 0, n_lsu = 0;

  task automatic finalize();
    chk("exec_count", n_exec, cur.alu ? 1 : 0);
    chk("cmp_count", n_cmp, cur.cmp ? 1 : 0);
    chk("regwr_count", n_wr, cur.wr ? 1 : 0);
    chk("lsu_req_count", n_lsu, cur.mem ? 1 : 0);
    chk("instr_cycles", cyc - hs_cyc, cur.lat);
    open = 0;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      cyc++;
      if (open && ((bus.io_instr_req_valid && !req_prev) || (bus.io_done && !done_prev)))
        finalize();
      if (bus.io_instr_req_valid) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL fetch_unexpected addr=%0h required=no fetch", bus.io_instr_req_addr);
        end else begin
          chk("fetch_addr", bus.io_instr_req_addr, exp_q[0].addr);
          if (bus.io_instr_resp_valid) begin
            cur = exp_q.pop_front();
            open = 1;
            hs_cyc = cyc;
            n_exec = 0; n_cmp = 0; n_wr = 0; n_lsu = 0;
          end
        end
      end
      if (bus.io_alu_execute) begin
        n_exec++;
        chk("exec_op", bus.io_alu_operation, cur.op);
        chk("exec_sel", {bus.io_rd_sel, bus.io_rs_sel, bus.io_rt_sel}, {cur.rd, cur.rs, cur.rt});
      end
      if (bus.io_alu_compare) n_cmp++;
      if (bus.io_reg_write) begin
        n_wr++;
        chk("wr_rd_imm", {bus.io_rd_sel, bus.io_imm}, {cur.rd, cur.imm});
      end
      if (bus.io_lsu_req) n_lsu++;
    end
    req_prev  = bus.io_instr_req_valid;
    done_prev = bus.io_done;
  end

  // Architectural interpreter: walks the program from PC 0 to RET
  task automatic run_model();
    logic [7:0]  pc = 8'h00;
    logic [15:0] w;
    logic [3:0]  op;
    exp_t        e;
    for (int k = 0; k < 400; k++) begin
      w  = prog[pc];
      op = w[15:12];
      e.addr = pc; e.op = op;
      e.rd = w[11:8]; e.rs = w[7:4]; e.rt = w[3:0]; e.imm = w[7:0];
      e.alu = (op >= 2 && op <= 7);
      e.cmp = (op == 2);
      e.wr  = (op >= 3 && op <= 7) || op == 8 || op == 4'hA;
      e.mem = (op == 8 || op == 9);
      e.lat = 6 + (e.mem ? busy_arr[k] : 0);
      exp_q.push_back(e);
      if (op == 2) nzp_model = res_arr[k][2:0];
      if (op == 4'hF) break;
      if (op == 1 && (w[11:9] & nzp_model) != 3'b000) pc = w[7:0];
      else pc = pc + 8'd1;
    end
  endtask

  task automatic prep();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    for (int k = 0; k < 512; k++) begin
      res_arr[k]   = 8'($urandom);
      busy_arr[k]  = $urandom_range(0, 5);
      delay_arr[k] = $urandom_range(0, 3);
    end
  endtask

  task automatic run_episode(input bit drop_mid);
    int t = 0;
    run_model();
    @(posedge clock); #1;
    bus.io_start = 1'b1;
    while (!bus.io_done && t < 2000) begin
      @(negedge clock);
      t++;
      if (drop_mid && t == 2) bus.io_start = 1'b0;
    end
    chk("done_reached", bus.io_done, 1'b1);
    if (!drop_mid) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clock);
        chk("done_held", bus.io_done, 1'b1);
      end
      @(posedge clock); #1;
      bus.io_start = 1'b0;
      @(negedge clock);
      chk("done_until_start_low", bus.io_done, 1'b1);
    end
    @(negedge clock);
    chk("idle_done_pc", {bus.io_done, bus.io_pc}, 9'h000);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.io_start = 1'b0;
    nzp_model = 3'b000;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_idle", {bus.io_instr_req_valid, bus.io_done, bus.io_pc}, 10'h0);

    // Reset in the middle of a stalled fetch
    @(posedge clock); #1;
    bus.io_start = 1'b1;
    repeat (3) @(negedge clock);
    chk("stalled_fetch", {bus.io_instr_req_valid, bus.io_instr_req_addr}, 9'h100);
    reset = 1'b1;
    #1;
    chk("reset_async_outputs",
        {bus.io_instr_req_valid, bus.io_pc, bus.io_lsu_req, bus.io_alu_execute,
         bus.io_alu_compare, bus.io_reg_write, bus.io_done, bus.io_alu_operation}, 18'h0);
    bus.io_start = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", {bus.io_instr_req_valid, bus.io_done}, 2'b00);
    resp_en = 1;
    mon_en = 1;

    // ADD r1,r2,r3 then RET
    prep(); prog[0] = 16'h3123; run_episode(0);
    // CMP -> N, BRn to 0x10 (taken)
    prep(); prog[0] = 16'h2012; prog[1] = 16'h1810; res_arr[0] = 8'h04; run_episode(0);
    // CMP -> P, BRn not taken
    prep(); prog[0] = 16'h2012; prog[1] = 16'h1810; res_arr[0] = 8'h01; run_episode(0);
    // LDR with 5 busy cycles
    prep(); prog[0] = 16'h8120; busy_arr[0] = 5; run_episode(0);
    // Branch to 0xFF, stalled fetch of a NOP there, wrap to 0, then not-taken exit
    prep(); prog[0] = 16'h2012; prog[1] = 16'h1EFF; prog[255] = 16'h0000;
    res_arr[0] = 8'h01; delay_arr[2] = 3; res_arr[3] = 8'h00; run_episode(0);
    // MUL r4,r5,r6
    prep(); prog[0] = 16'h5456; run_episode(0);
    // Mask 000 is never taken, whatever NZP holds
    prep(); prog[0] = 16'h2000; prog[1] = 16'h1020; prog[2] = 16'h0000;
    res_arr[0] = 8'h07; run_episode(1);

    // Random programs with forward-only branches
    for (int ep = 0; ep < 20; ep++) begin
      prep();
      for (int i = 0; i < 250; i++) begin
        logic [15:0] w;
        int tg;
        w = 16'($urandom);
        if (w[15:12] == 4'h1) begin
          tg = i + 1 + $urandom_range(0, 7);
          if (tg > 255) tg = 255;
          w[7:0] = tg[7:0];
        end
        prog[i] = w;
      end
      run_episode($urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
